pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the program counter and sequences instruction fetch for the RISC-V core.
//  Selects next PC (sequential +4, EX-stage branch/jump redirect, trap vector), drives the
//  req/ack instruction-memory port, and hands fetched words to decode via valid/ready.
//  Sits between the PC register, instruction memory and the IF/ID stage.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset
//  TRAP_VEC  32'h0000_0100  target on trap_i or misaligned redirect
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   synchronous, active-high reset
//  redirect_i     in   1   branch/jump taken (EX stage), 1-cycle pulse
//  redirect_pc_i  in   32  redirect target
//  trap_i         in   1   exception/trap request, 1-cycle pulse
//  halt_i         in   1   ebreak/halt request
//  imem_req_o     out  1   fetch request
//  imem_addr_o    out  32  fetch address (= PC)
//  imem_ack_i     in   1   memory returns imem_rdata_i this cycle
//  imem_rdata_i   in   32  instruction word
//  if_valid_o     out  1   fetched instruction available to decode
//  if_pc_o        out  32  PC of presented instruction
//  if_instr_o     out  32  presented instruction
//  if_ready_i     in   1   decode accepts instruction
//  misalign_o     out  1   1-cycle pulse: redirect target[1:0]!=0
//  halted_o       out  1   sequencer in HALT
// BEHAVIOUR
//  States: BOOT, FETCH, HOLD, HALT. Reset -> BOOT; imem_req_o=0, imem_addr_o=RESET_PC,
//   if_valid_o=0, if_pc_o=0, if_instr_o=0, misalign_o=0, halted_o=0, pending redirect cleared.
//  BOOT: one cycle, no request -> FETCH. First imem_req_o in 2nd cycle after rst deasserts.
//  FETCH: imem_req_o=1; imem_addr_o held stable until imem_ack_i (memory protocol rule).
//   On ack without pending redirect: if_instr_o<=rdata, if_pc_o<=PC, if_valid_o<=1,
//   PC<=PC+4 (mod 2^32, 0xFFFF_FFFC -> 0), -> HOLD. Ack-to-valid latency 1 cycle.
//  HOLD: imem_req_o=0, outputs stable; if_ready_i=1 -> if_valid_o<=0, -> FETCH.
//  Next-PC priority: rst > trap_i > redirect_i > sequential.
//  trap_i / redirect_i in HOLD or FETCH with ack same cycle: fetched/presented word dropped
//   (if_valid_o<=0), PC<=target, -> FETCH.
//  redirect/trap in FETCH without ack: target latched in pending register (later event
//   overwrites earlier); request keeps old address; on ack data discarded, PC<=pending, stay FETCH.
//  Misaligned redirect (redirect_pc_i[1:0]!=0): treated as trap -> target TRAP_VEC,
//   misalign_o=1 for exactly one cycle (cycle after redirect_i).
//  halt_i: in HOLD/BOOT immediate -> HALT; in FETCH waits for ack (data dropped) -> HALT.
//   HALT: no requests, if_valid_o=0, halted_o=1; exit only via rst.
//  rst mid-FETCH: imem_req_o=0 next cycle, any late ack ignored in BOOT.
// TESTING
//  1 rst 2 cyc, ack every req, ready=1 -> imem_addr_o 0,4,8,C; if_pc_o tracks, 1-cyc latency.
//  2 Req addr 8 pending, redirect_pc_i=0x200, ack 2 cyc later with 0xDEADBEEF -> never
//    valid; next req addr 0x200.
//  3 redirect_pc_i=0x202 -> misalign_o one-cycle pulse, next req addr 0x100.
//  4 if_ready_i=0 for 3 cyc after valid -> if_valid_o/if_instr_o held, imem_req_o=0.
//  5 RESET_PC=0xFFFF_FFFC -> addrs 0xFFFF_FFFC then 0x0; trap_i+redirect same cyc -> 0x100.
//  6 rst during FETCH wait -> req drops next cyc, reissue at RESET_PC; halt_i -> halted_o=1, no req.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter owner and instruction-fetch sequencer.
//                Picks the next PC (sequential, redirect, trap vector),
//                runs the req/ack instruction-memory port and presents
//                fetched words to decode over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        trap_i,
    input  logic        halt_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    input  logic        if_ready_i,
    output logic        misalign_o,
    output logic        halted_o
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [31:0] c_PC_STEP = 32'd4;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_pend_vld;
    logic [31:0] r_pend_pc;
    logic        r_halt_pend;
    logic        r_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic        r_misalign;

    logic        w_event;
    logic        w_redir_mis;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    // Redirect target resolution: trap beats redirect; a misaligned redirect
    // is turned into a trap so the core never fetches from a bad address.
    always_comb begin
        w_event     = trap_i | redirect_i;
        w_redir_mis = redirect_i & ~trap_i & (redirect_pc_i[1:0] != 2'b00);
        w_target    = redirect_pc_i;
        if (trap_i || w_redir_mis) begin
            w_target = TRAP_VEC;
        end
        w_pc_inc = r_pc + c_PC_STEP;
    end

    // Fetch sequencer: PC, pending redirect, presented instruction and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_BOOT;
            r_pc        <= RESET_PC;
            r_pend_vld  <= 1'b0;
            r_pend_pc   <= 32'h0;
            r_halt_pend <= 1'b0;
            r_valid     <= 1'b0;
            r_if_pc     <= 32'h0;
            r_if_instr  <= 32'h0;
            r_misalign  <= 1'b0;
        end else begin
            r_misalign <= (r_state != S_HALT) && w_redir_mis;
            case (r_state)
                S_BOOT: begin
                    if (halt_i) begin
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_FETCH;
                        if (w_event) begin
                            r_pc <= w_target;
                        end
                    end
                end
                S_FETCH: begin
                    if (imem_ack_i) begin
                        // Address may only move once the memory has answered.
                        r_pend_vld <= 1'b0;
                        if (halt_i || r_halt_pend) begin
                            r_halt_pend <= 1'b0;
                            r_state     <= S_HALT;
                        end else if (w_event) begin
                            r_pc <= w_target;
                        end else if (r_pend_vld) begin
                            r_pc <= r_pend_pc;
                        end else begin
                            r_if_instr <= imem_rdata_i;
                            r_if_pc    <= r_pc;
                            r_valid    <= 1'b1;
                            r_pc       <= w_pc_inc;
                            r_state    <= S_HOLD;
                        end
                    end else begin
                        if (halt_i) begin
                            r_halt_pend <= 1'b1;
                        end
                        // Later events overwrite earlier ones while waiting.
                        if (w_event) begin
                            r_pend_vld <= 1'b1;
                            r_pend_pc  <= w_target;
                        end
                    end
                end
                S_HOLD: begin
                    if (halt_i) begin
                        r_valid <= 1'b0;
                        r_state <= S_HALT;
                    end else if (w_event) begin
                        r_valid <= 1'b0;
                        r_pc    <= w_target;
                        r_state <= S_FETCH;
                    end else if (if_ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

    assign imem_req_o  = (r_state == S_FETCH);
    assign imem_addr_o = r_pc;
    assign if_valid_o  = r_valid;
    assign if_pc_o     = r_if_pc;
    assign if_instr_o  = r_if_instr;
    assign misalign_o  = r_misalign;
    assign halted_o    = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Scoreboard testbench for pc_sequencer. Directed stimulus
//                pushes expected fetch addresses and presented instructions;
//                a negedge monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        trap_i = 1'b0;
    logic        halt_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        if_ready_i = 1'b1;
    logic        misalign_o;
    logic        halted_o;

    // second instance with a wrapping reset PC
    logic        req2;
    logic [31:0] addr2;
    logic        ack2;
    logic [31:0] rdata2;
    logic        valid2;
    logic [31:0] pc2;
    logic [31:0] instr2;
    logic        mis2;
    logic        halted2;
    logic        mem2_en = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_out_q[$];

    int          budget = 0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_data = 32'h0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .trap_i        (trap_i),
        .halt_i        (halt_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o),
        .if_ready_i    (if_ready_i),
        .misalign_o    (misalign_o),
        .halted_o      (halted_o)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .TRAP_VEC(32'h0000_0100)) dut2 (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (1'b0),
        .redirect_pc_i (32'h0),
        .trap_i        (1'b0),
        .halt_i        (1'b0),
        .imem_req_o    (req2),
        .imem_addr_o   (addr2),
        .imem_ack_i    (ack2),
        .imem_rdata_i  (rdata2),
        .if_valid_o    (valid2),
        .if_pc_o       (pc2),
        .if_instr_o    (instr2),
        .if_ready_i    (1'b1),
        .misalign_o    (mis2),
        .halted_o      (halted2)
    );

    assign ack2   = req2 & mem2_en;
    assign rdata2 = addr2 ^ 32'h0F0F_0F0F;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction memory: zero-wait ack while the ack budget lasts.
    initial begin
        imem_ack_i   = 1'b0;
        imem_rdata_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_req_o && budget > 0) begin
                imem_ack_i = 1'b1;
                if (ovr_en) begin
                    imem_rdata_i = ovr_data;
                    ovr_en       = 1'b0;
                end else begin
                    imem_rdata_i = imem_addr_o ^ 32'hA5A5_0000;
                end
                budget--;
            end else begin
                imem_ack_i   = 1'b0;
                imem_rdata_i = 32'h0;
            end
        end
    end

    // Monitor: acked fetch addresses and accepted instructions.
    always @(negedge clk) begin
        if (!rst && imem_req_o && imem_ack_i) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fetch_addr unexpected got %h expected none", imem_addr_o);
            end else begin
                check32("fetch_addr", imem_addr_o, exp_addr_q.pop_front());
            end
        end
        if (!rst && if_valid_o && if_ready_i) begin
            if (exp_out_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL if_out unexpected got pc %h instr %h expected none", if_pc_o, if_instr_o);
            end else begin
                logic [63:0] e;
                e = exp_out_q.pop_front();
                check32("if_pc", if_pc_o, e[63:32]);
                check32("if_instr", if_instr_o, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic push(input logic [31:0] a);
        exp_addr_q.push_back(a);
    endtask

    task automatic push_out(input logic [31:0] p, input logic [31:0] i);
        exp_out_q.push_back({p, i});
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while ((exp_addr_q.size() != 0 || exp_out_q.size() != 0) && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (exp_addr_q.size() != 0 || exp_out_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d addr / %0d out pending expected 0", exp_addr_q.size(), exp_out_q.size());
        end
    endtask

    task automatic do_reset();
        budget = 0;
        rst    = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        logic [31:0] a2[$];
        logic [63:0] o2[$];
        int n;

        // Reset state
        tick();
        tick();
        check32("rst_req", {31'h0, imem_req_o}, 32'h0);
        check32("rst_addr", imem_addr_o, 32'h0);
        check32("rst_valid", {31'h0, if_valid_o}, 32'h0);
        check32("rst_if_pc", if_pc_o, 32'h0);
        check32("rst_if_instr", if_instr_o, 32'h0);
        check32("rst_misalign", {31'h0, misalign_o}, 32'h0);
        check32("rst_halted", {31'h0, halted_o}, 32'h0);

        // 1: sequential fetch 0,4,8,C
        push(32'h0);  push_out(32'h0, 32'hA5A5_0000);
        push(32'h4);  push_out(32'h4, 32'hA5A5_0004);
        push(32'h8);  push_out(32'h8, 32'hA5A5_0008);
        push(32'hC);  push_out(32'hC, 32'hA5A5_000C);
        budget = 4;
        rst = 1'b0;
        check32("boot_no_req", {31'h0, imem_req_o}, 32'h0);
        tick();
        check32("first_req", {31'h0, imem_req_o}, 32'h1);
        check32("first_addr", imem_addr_o, 32'h0);
        wait_drain(40);

        // 2: redirect while fetch of 0x8 is outstanding
        do_reset();
        push(32'h0); push_out(32'h0, 32'hA5A5_0000);
        push(32'h4); push_out(32'h4, 32'hA5A5_0004);
        budget = 2;
        rst = 1'b0;
        wait_drain(30);
        check32("t2_wait_addr", imem_addr_o, 32'h8);
        redirect_i = 1'b1; redirect_pc_i = 32'h200;
        tick();
        redirect_i = 1'b0;
        check32("t2_addr_stable", imem_addr_o, 32'h8);
        check32("t2_req_kept", {31'h0, imem_req_o}, 32'h1);
        tick();
        push(32'h8);
        push(32'h200); push_out(32'h200, 32'hA5A5_0200);
        ovr_data = 32'hDEAD_BEEF; ovr_en = 1'b1;
        budget = 2;
        wait_drain(30);

        // 3: misaligned redirect -> trap vector, one-cycle misalign pulse
        check32("t3_wait_addr", imem_addr_o, 32'h204);
        redirect_i = 1'b1; redirect_pc_i = 32'h202;
        tick();
        redirect_i = 1'b0;
        check32("t3_mis_pulse", {31'h0, misalign_o}, 32'h1);
        tick();
        check32("t3_mis_clear", {31'h0, misalign_o}, 32'h0);
        push(32'h204);
        push(32'h100); push_out(32'h100, 32'hA5A5_0100);
        budget = 2;
        wait_drain(30);

        // 4: decode stalls for 3 cycles
        if_ready_i = 1'b0;
        push(32'h104); push_out(32'h104, 32'hA5A5_0104);
        budget = 1;
        n = 0;
        while (!imem_ack_i && n < 10) begin
            tick();
            n++;
        end
        check32("t4_ack_seen", {31'h0, imem_ack_i}, 32'h1);
        tick();
        check32("t4_latency", {31'h0, if_valid_o}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            check32("t4_hold_valid", {31'h0, if_valid_o}, 32'h1);
            check32("t4_hold_instr", if_instr_o, 32'hA5A5_0104);
            check32("t4_hold_noreq", {31'h0, imem_req_o}, 32'h0);
            tick();
        end
        if_ready_i = 1'b1;
        wait_drain(20);

        // 5: wrapping reset PC on second instance; trap+redirect together
        do_reset();
        mem2_en = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (req2 && ack2) a2.push_back(addr2);
            if (valid2) o2.push_back({pc2, instr2});
        end
        mem2_en = 1'b0;
        checks++;
        if (a2.size() < 2 || o2.size() < 2) begin
            errors++;
            $display("FAIL wrap_count got %0d fetches expected at least 2", a2.size());
        end else begin
            check32("wrap_addr0", a2[0], 32'hFFFF_FFFC);
            check32("wrap_addr1", a2[1], 32'h0000_0000);
            check32("wrap_pc0", o2[0][63:32], 32'hFFFF_FFFC);
            check32("wrap_instr0", o2[0][31:0], 32'hF0F0_F0F3);
            check32("wrap_pc1", o2[1][63:32], 32'h0000_0000);
        end
        check32("t5_wait_addr", imem_addr_o, 32'h0);
        trap_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h300;
        tick();
        trap_i = 1'b0; redirect_i = 1'b0;
        check32("t5_no_mis", {31'h0, misalign_o}, 32'h0);
        push(32'h0);
        push(32'h100); push_out(32'h100, 32'hA5A5_0100);
        budget = 2;
        wait_drain(30);

        // 6: reset during fetch wait, then halt
        check32("t6_req_before", {31'h0, imem_req_o}, 32'h1);
        rst = 1'b1;
        tick();
        check32("t6_req_drop", {31'h0, imem_req_o}, 32'h0);
        check32("t6_addr_reset", imem_addr_o, 32'h0);
        push(32'h0); push_out(32'h0, 32'hA5A5_0000);
        budget = 1;
        rst = 1'b0;
        wait_drain(20);
        halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        check32("t6_halt_wait", {31'h0, halted_o}, 32'h0);
        check32("t6_halt_req", {31'h0, imem_req_o}, 32'h1);
        push(32'h4);
        budget = 1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            check32("t6_halted", {31'h0, halted_o}, 32'h1);
            check32("t6_halt_noreq", {31'h0, imem_req_o}, 32'h0);
            check32("t6_halt_novalid", {31'h0, if_valid_o}, 32'h0);
            tick();
        end
        budget = 0;
        wait_drain(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
